wb_arbiter: RTL and testbench

//   Write-back arbiter that drives the single register-file write port (we/waddr/wdata).

---
 rtl/mips_pkg.sv | 15 +
 rtl/wb_fifo.sv | 54 +++++
 rtl/wb_arbiter.sv | 101 ++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared core definitions: register-file geometry and the write-back request record
// carried by both write-back sources.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [DATA_W-1:0]     wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency write-back requests until the register-file
// port is free. Pointers wrap modulo DEPTH; the extra count bit separates full from empty.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; occupancy is tracked by count, so stale words are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: the pipeline slot always wins the register-file port; long-latency
// results are bypassed straight through when idle, otherwise queued in order.
module wb_arbiter #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int ADDR_W     = mips_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pipe_we,
  input  logic [ADDR_W-1:0] i_pipe_waddr,
  input  logic [DATA_W-1:0] i_pipe_wdata,
  input  logic              i_lu_valid,
  output logic              o_lu_ready,
  input  logic [ADDR_W-1:0] i_lu_waddr,
  input  logic [DATA_W-1:0] i_lu_wdata,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [CNT_W-1:0]  o_fifo_cnt
);

  import mips_pkg::*;

  wb_req_t pipe_req;
  wb_req_t lu_req;
  wb_req_t head_req;
  wb_req_t rf_req;
  wb_req_t next_req;

  logic pipe_wr;
  logic lu_xfer;
  logic lu_keep;
  logic bypass;
  logic fifo_push;
  logic fifo_pop;
  logic fifo_full;
  logic fifo_empty;
  logic next_we;
  logic rf_we;

  assign pipe_req = '{waddr: i_pipe_waddr, wdata: i_pipe_wdata};
  assign lu_req   = '{waddr: i_lu_waddr,   wdata: i_lu_wdata};

  // Ready depends only on registered occupancy and reset, never on i_lu_valid.
  assign o_lu_ready = i_rst_n && !fifo_full;

  assign pipe_wr   = i_pipe_we && (i_pipe_waddr != REG_ZERO);
  assign lu_xfer   = i_lu_valid && o_lu_ready;
  assign lu_keep   = lu_xfer && (i_lu_waddr != REG_ZERO);
  assign fifo_pop  = !pipe_wr && !fifo_empty;
  assign bypass    = !pipe_wr && fifo_empty && lu_keep;
  assign fifo_push = lu_keep && !bypass;

  wb_fifo #(
    .WIDTH ($bits(wb_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (fifo_push),
    .push_data (lu_req),
    .pop       (fifo_pop),
    .head      (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_fifo_cnt)
  );

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    next_we  = 1'b0;
    next_req = rf_req;
    if (pipe_wr) begin
      next_we  = 1'b1;
      next_req = pipe_req;
    end else if (fifo_pop) begin
      next_we  = 1'b1;
      next_req = head_req;
    end else if (bypass) begin
      next_we  = 1'b1;
      next_req = lu_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rf_we  <= 1'b0;
      rf_req <= '0;
    end else begin
      rf_we  <= next_we;
      rf_req <= next_req;
    end
  end

  assign o_rf_we    = rf_we;
  assign o_rf_waddr = rf_req.waddr;
  assign o_rf_wdata = rf_req.wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single-cycle vectors from a table, then hand-built
// sequences for back-pressure, wrap-around ordering and mid-drain reset.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  fifo_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_ready;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vecs [12];
  vec_t seq  [8];

  wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pipe_we    (pipe_we),
    .i_pipe_waddr (pipe_waddr),
    .i_pipe_wdata (pipe_wdata),
    .i_lu_valid   (lu_valid),
    .o_lu_ready   (lu_ready),
    .i_lu_waddr   (lu_waddr),
    .i_lu_wdata   (lu_wdata),
    .o_rf_we      (rf_we),
    .o_rf_waddr   (rf_waddr),
    .o_rf_wdata   (rf_wdata),
    .o_fifo_cnt   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                              input logic lv, input logic [4:0] la, input logic [31:0] ld,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                              input logic er, input logic [2:0] ec);
    vec_t v;
    v.pipe_we = pw; v.pipe_waddr = pa; v.pipe_wdata = pd;
    v.lu_valid = lu_valid_fix(lv); v.lu_waddr = la; v.lu_wdata = ld;
    v.exp_we = ew; v.exp_waddr = ea; v.exp_wdata = ed;
    v.exp_ready = er; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic lu_valid_fix(input logic lv);
    return lv;
  endfunction

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
  endtask

  // Drives one cycle of stimulus and compares the registered result just after the edge.
  task automatic apply_vec(input string tag, input vec_t v);
    drive(v.pipe_we, v.pipe_waddr, v.pipe_wdata, v.lu_valid, v.lu_waddr, v.lu_wdata);
    @(posedge clk);
    #1;
    check({tag, " we"},    32'(rf_we),    32'(v.exp_we));
    if (v.exp_we) begin
      check({tag, " waddr"}, 32'(rf_waddr), 32'(v.exp_waddr));
      check({tag, " wdata"}, rf_wdata,      v.exp_wdata);
    end
    check({tag, " ready"}, 32'(lu_ready), 32'(v.exp_ready));
    check({tag, " cnt"},   32'(fifo_cnt), 32'(v.exp_cnt));
  endtask

  initial begin
    // Single-cycle vectors, applied from reset state (cnt=0, outputs 0).
    vecs[0]  = mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'hDEAD_BEEF, 1'b1, 3'd0);
    vecs[1]  = mk(1'b1, 5'd0, 32'h0000_1111, 1'b0, 5'd0,  32'h0,      1'b0, 5'd5,  32'hDEAD_BEEF, 1'b1, 3'd0);
    vecs[2]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd7,  32'h1234,   1'b1, 5'd7,  32'h1234,      1'b1, 3'd0);
    vecs[3]  = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,      1'b0, 5'd7,  32'h1234,      1'b1, 3'd0);
    vecs[4]  = mk(1'b1, 5'd9, 32'hAAAA,      1'b1, 5'd10, 32'hBBBB,   1'b1, 5'd9,  32'hAAAA,      1'b1, 3'd1);
    vecs[5]  = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,      1'b1, 5'd10, 32'hBBBB,      1'b1, 3'd0);
    vecs[6]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd0,  32'hCCCC,   1'b0, 5'd10, 32'hBBBB,      1'b1, 3'd0);
    vecs[7]  = mk(1'b1, 5'd3, 32'h33,        1'b1, 5'd0,  32'hDDDD,   1'b1, 5'd3,  32'h33,        1'b1, 3'd0);
    vecs[8]  = mk(1'b1, 5'd4, 32'h44,        1'b1, 5'd11, 32'hB011,   1'b1, 5'd4,  32'h44,        1'b1, 3'd1);
    vecs[9]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd12, 32'hB012,   1'b1, 5'd11, 32'hB011,      1'b1, 3'd1);
    vecs[10] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,      1'b1, 5'd12, 32'hB012,      1'b1, 3'd0);
    vecs[11] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,      1'b0, 5'd12, 32'hB012,      1'b1, 3'd0);

    // Simultaneous push/pop at cnt=2 across the pointer wrap.
    seq[0] = mk(1'b1, 5'd21, 32'hE0, 1'b1, 5'd13, 32'hA1, 1'b1, 5'd21, 32'hE0, 1'b1, 3'd1);
    seq[1] = mk(1'b1, 5'd22, 32'hE1, 1'b1, 5'd14, 32'hB2, 1'b1, 5'd22, 32'hE1, 1'b1, 3'd2);
    seq[2] = mk(1'b0, 5'd0,  32'h0,  1'b1, 5'd15, 32'hC3, 1'b1, 5'd13, 32'hA1, 1'b1, 3'd2);
    seq[3] = mk(1'b0, 5'd0,  32'h0,  1'b1, 5'd16, 32'hD4, 1'b1, 5'd14, 32'hB2, 1'b1, 3'd2);
    seq[4] = mk(1'b0, 5'd0,  32'h0,  1'b1, 5'd17, 32'hE5, 1'b1, 5'd15, 32'hC3, 1'b1, 3'd2);
    seq[5] = mk(1'b0, 5'd0,  32'h0,  1'b1, 5'd18, 32'hF6, 1'b1, 5'd16, 32'hD4, 1'b1, 3'd2);
    seq[6] = mk(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 5'd17, 32'hE5, 1'b1, 3'd1);
    seq[7] = mk(1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 5'd18, 32'hF6, 1'b1, 3'd0);

    // Reset held with a valid LU result pending.
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h5555);
    repeat (3) @(posedge clk);
    #1;
    check("reset we",    32'(rf_we),    32'd0);
    check("reset ready", 32'(lu_ready), 32'd0);
    check("reset cnt",   32'(fifo_cnt), 32'd0);
    check("reset waddr", 32'(rf_waddr), 32'd0);
    lu_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("release ready", 32'(lu_ready), 32'd1);

    for (int i = 0; i < 12; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Collision: pipe busy 6 cycles while LU offers r1..r5, then drain.
    begin
      int idx = 0;
      logic xfer;
      logic [2:0] exp_cnt [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      for (int c = 0; c < 11; c++) begin
        drive(c < 6, 5'(20 + c), 32'hA000 + 32'(c),
              idx < 5, 5'(idx + 1), 32'h100 + 32'(idx + 1));
        #1;
        check($sformatf("coll%0d ready", c), 32'(lu_ready), 32'((c < 4) || (c > 6)));
        xfer = lu_valid && lu_ready;
        @(posedge clk);
        #1;
        if (xfer) idx++;
        check($sformatf("coll%0d cnt", c), 32'(fifo_cnt), 32'(exp_cnt[c]));
        check($sformatf("coll%0d we", c),  32'(rf_we),    32'd1);
        if (c < 6) begin
          check($sformatf("coll%0d waddr", c), 32'(rf_waddr), 32'(20 + c));
          check($sformatf("coll%0d wdata", c), rf_wdata,      32'hA000 + 32'(c));
        end else begin
          check($sformatf("coll%0d waddr", c), 32'(rf_waddr), 32'(c - 5));
          check($sformatf("coll%0d wdata", c), rf_wdata,      32'h100 + 32'(c - 5));
        end
      end
      check("coll accepted", 32'(idx), 32'd5);
    end

    for (int i = 0; i < 8; i++) apply_vec($sformatf("wrap%0d", i), seq[i]);

    // Fill to 4, pop one (cnt=3), then reset asynchronously between edges.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 5'(24 + k), 32'h200 + 32'(k), 1'b1, 5'(k + 1), 32'h300 + 32'(k));
      @(posedge clk);
      #1;
    end
    check("fill cnt", 32'(fifo_cnt), 32'd4);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1;
    check("drain waddr", 32'(rf_waddr), 32'd1);
    check("drain wdata", rf_wdata,      32'h300);
    check("drain cnt",   32'(fifo_cnt), 32'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("async we",    32'(rf_we),    32'd0);
    check("async cnt",   32'(fifo_cnt), 32'd0);
    check("async ready", 32'(lu_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post%0d we", k),  32'(rf_we),    32'd0);
      check($sformatf("post%0d cnt", k), 32'(fifo_cnt), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
